// File: rtl/lsu.sv
// lsu: multi-cycle load/store unit placed after the ALU.
//
// Takes the ALU result as the effective address and rs2 as store data, runs one
// request/acknowledge transaction on the data-memory port and returns sign- or
// zero-extended load data. o_stall freezes the PC and regfile writeback until
// the access retires in RESP.
//
// Optional feature macro: LSU_TIMEOUT_EN adds a BUSY watchdog that ends the
// access with o_bus_err after TIMEOUT cycles without an ack. Without it BUSY
// waits indefinitely and o_bus_err is tied low.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_lsu_valid       load/store presented (sampled only in IDLE)
//   i_lsu_wren        1 = store, 0 = load
//   i_funct3          RV32I width/sign encoding
//   i_alu_data        effective address
//   i_rs2_data        store data
//   o_stall           combinational pipeline freeze
//   o_done            one-cycle completion pulse
//   o_ld_data         extended load data, valid with o_done
//   o_misaligned      misaligned or illegal funct3, valid with o_done
//   o_bus_err         watchdog timeout, valid with o_done
//   o_mem_*           memory request port, held stable while BUSY
//   i_mem_ack         memory accepted write / returned read
//   i_mem_rdata       read word, valid with i_mem_ack
module lsu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_lsu_valid,
  input  logic             i_lsu_wren,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_alu_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_ld_data,
  output logic             o_misaligned,
  output logic             o_bus_err,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic [3:0]       o_mem_bmask,
  input  logic             i_mem_ack,
  input  logic [WIDTH-1:0] i_mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             wren_q;
  logic [2:0]       funct3_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [3:0]       bmask_q;
  logic             mis_q;
  logic [WIDTH-1:0] ld_q;

  logic             illegal;
  logic             misaligned;
  logic             req_err;
  logic [WIDTH-1:0] wdata_c;
  logic [3:0]       bmask_c;
  logic [WIDTH-1:0] rd_shift;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] ld_ext;
  logic             timeout;

  // Decode of the request presented in IDLE.
  always_comb begin
    if (i_lsu_wren) begin
      illegal = (i_funct3 > 3'd2);
    end else begin
      illegal = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
    end

    case (i_funct3[1:0])
      2'b01:   misaligned = i_alu_data[0];
      2'b10:   misaligned = |i_alu_data[1:0];
      default: misaligned = 1'b0;
    endcase
    req_err = illegal | misaligned;

    // Loads read the whole word; extraction happens on the returned data.
    wdata_c = '0;
    bmask_c = 4'b1111;
    if (i_lsu_wren) begin
      case (i_funct3[1:0])
        2'b00: begin
          wdata_c = {4{i_rs2_data[7:0]}};
          bmask_c = 4'b0001 << i_alu_data[1:0];
        end
        2'b01: begin
          wdata_c = {2{i_rs2_data[15:0]}};
          bmask_c = i_alu_data[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_c = i_rs2_data;
          bmask_c = 4'b1111;
        end
      endcase
    end
  end

  // Lane extraction and extension of the returned read word.
  always_comb begin
    rd_shift = i_mem_rdata >> {addr_q[1:0], 3'b000};
    ld_byte  = rd_shift[7:0];
    ld_half  = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'b0, ld_byte};
      3'b101:  ld_ext = {16'b0, ld_half};
      default: ld_ext = i_mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [4:0] cnt_q;
  logic       bus_err_q;

  // An ack in the limit cycle takes priority over the timeout.
  assign timeout = (state_q == BUSY) && !i_mem_ack && (cnt_q == 5'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else if (state_q == IDLE) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else if (state_q == BUSY && !i_mem_ack) begin
      cnt_q <= cnt_q + 5'd1;
      if (timeout) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  assign o_bus_err = (state_q == RESP) && bus_err_q;
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
  assign o_bus_err      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_lsu_valid) state_d = req_err ? RESP : BUSY;
      BUSY:    if (i_mem_ack || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      wren_q   <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      bmask_q  <= '0;
      mis_q    <= 1'b0;
      ld_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && i_lsu_valid) begin
        wren_q   <= i_lsu_wren;
        funct3_q <= i_funct3;
        addr_q   <= i_alu_data;
        wdata_q  <= wdata_c;
        bmask_q  <= bmask_c;
        mis_q    <= req_err;
        ld_q     <= '0;  // stays zero for errors, stores and timeouts
      end
      if (state_q == BUSY && i_mem_ack) begin
        ld_q <= wren_q ? '0 : ld_ext;
      end
    end
  end

  // Memory outputs are only driven during BUSY so they read zero otherwise.
  assign o_mem_req    = (state_q == BUSY);
  assign o_mem_we     = o_mem_req && wren_q;
  assign o_mem_addr   = o_mem_req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
  assign o_mem_wdata  = o_mem_req ? wdata_q : '0;
  assign o_mem_bmask  = o_mem_req ? bmask_q : 4'b0000;

  assign o_stall      = ((state_q == IDLE) && i_lsu_valid) || (state_q == BUSY);
  assign o_done       = (state_q == RESP);
  assign o_misaligned = o_done && mis_q;
  assign o_ld_data    = o_done ? ld_q : '0;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized scoreboard bench for lsu.
// The stimulus process pushes expected completions and expected memory
// requests; a memory responder and a completion monitor compare independently.
module tb_lsu;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_valid = 1'b0;
  logic        lsu_wren = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] alu_data = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic        stall, done, misaligned, bus_err;
  logic [31:0] ld_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_bmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  lsu #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_lsu_valid  (lsu_valid),
    .i_lsu_wren   (lsu_wren),
    .i_funct3     (funct3),
    .i_alu_data   (alu_data),
    .i_rs2_data   (rs2_data),
    .o_stall      (stall),
    .o_done       (done),
    .o_ld_data    (ld_data),
    .o_misaligned (misaligned),
    .o_bus_err    (bus_err),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_bmask  (mem_bmask),
    .i_mem_ack    (mem_ack),
    .i_mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        berr;
    int          lat;
    int          stall;
    int          accept;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic [31:0] rdata;
    int          delay;  // ack in this BUSY cycle; 0 = never ack
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   issued = 0;
  int   stall_cnt = 0;
  int   busy_cnt = 0;
  bit   armed = 1'b0;
  bit   abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, want, cyc);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic chk_reset();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_misaligned", 32'(misaligned), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_bmask", 32'(mem_bmask), 0);
  endtask

  // Completion monitor.
  always @(negedge clk) begin
    if (armed) begin
      if (rst) begin
        stall_cnt = 0;
      end else begin
        if (stall) stall_cnt++;
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            fail("done_without_request");
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ld_data", ld_data, e.ld);
            chk("misaligned", 32'(misaligned), 32'(e.mis));
            chk("bus_err", 32'(bus_err), 32'(e.berr));
            chk("latency", 32'(cyc - e.accept), 32'(e.lat));
            chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
          end
          stall_cnt = 0;
        end else begin
          chk("ld_data_idle", ld_data, 0);
        end
      end
    end
  end

  // Memory responder: checks every request cycle against the front entry,
  // which also proves the request is held stable until ack.
  always @(negedge clk) begin
    if (armed) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (req_q.size() == 0) begin
          fail("mem_req_unexpected");
        end else begin
          req_t r;
          r = req_q[0];
          chk("mem_addr", mem_addr, r.addr);
          chk("mem_we", 32'(mem_we), 32'(r.we));
          chk("mem_bmask", 32'(mem_bmask), 32'(r.bmask));
          if (r.we) chk("mem_wdata", mem_wdata, r.wdata);
          busy_cnt++;
          if (r.delay != 0 && busy_cnt == r.delay) begin
            mem_ack   = 1'b1;
            mem_rdata = r.rdata;
            void'(req_q.pop_front());
            busy_cnt  = 0;
          end else if (r.delay == 0 && busy_cnt == int'(TIMEOUT)) begin
            void'(req_q.pop_front());
            busy_cnt = 0;
          end
        end
      end else begin
        busy_cnt = 0;
        if ($urandom_range(7) == 0) mem_ack = 1'b1;  // stray ack must be ignored
      end
    end
  end

  // Reference model from the architectural rules, then drive and wait.
  task automatic issue(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [31:0] rdata, input int delay,
                       input bit noise);
    exp_t        e;
    req_t        r;
    int          nb;
    int          off;
    int          t;
    bit          legal;
    logic [31:0] m;
    nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(addr[1:0]);
    legal = wren ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    e.accept = cyc;
    if (!legal || (off % nb) != 0) begin
      e.ld = 0; e.mis = 1'b1; e.berr = 1'b0; e.lat = 1; e.stall = 1;
    end else begin
      r.addr  = addr - 32'(off);
      r.we    = wren;
      r.rdata = rdata;
      r.delay = delay;
      r.bmask = wren ? 4'(((1 << nb) - 1) << off) : 4'hF;
      r.wdata = 0;
      for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = rs2[8*(i % nb) +: 8];
      e.mis = 1'b0; e.berr = 1'b0; e.lat = delay + 1; e.stall = delay + 1;
      if (wren) begin
        e.ld = 0;
      end else begin
        m    = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        e.ld = (rdata >> (8 * off)) & m;
        if (nb < 4 && !f3[2] && e.ld[8*nb-1]) e.ld = e.ld | ~m;
      end
      if (delay == 0) begin
        e.ld = 0; e.berr = 1'b1; e.lat = TIMEOUT + 1; e.stall = TIMEOUT + 1;
      end
      req_q.push_back(r);
    end
    exp_q.push_back(e);
    issued++;
    lsu_valid = 1'b1; lsu_wren = wren; funct3 = f3; alu_data = addr; rs2_data = rs2;
    @(posedge clk); #1;
    t = 0;
    while (done_cnt < issued && t < 40) begin
      // Optional junk on the request inputs while the access is in flight.
      lsu_valid = noise && ($urandom_range(1) == 1);
      if (lsu_valid) begin
        lsu_wren = 1'($urandom_range(1));
        funct3   = 3'($urandom_range(7));
        alu_data = $urandom;
        rs2_data = $urandom;
      end
      @(posedge clk); #1;
      t++;
    end
    lsu_valid = 1'b0;
    if (done_cnt < issued) begin
      fail("done_timeout");
      abort = 1'b1;
    end
  endtask

  initial begin
    req_t rr;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1;

    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0);
    issue(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 4, 1'b0);
    issue(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 4, 1'b1);
    issue(1'b1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 2, 1'b0);
    issue(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 1'b0);
    issue(1'b1, 3'b001, 32'h401, 32'h1234, 32'h0, 1, 1'b0);

    // Reset while BUSY: the access is abandoned with no completion.
    rr.addr = 32'h500; rr.we = 1'b0; rr.wdata = 0; rr.bmask = 4'hF;
    rr.rdata = 32'h0; rr.delay = 10;
    req_q.push_back(rr);
    lsu_valid = 1'b1; lsu_wren = 1'b0; funct3 = 3'b010; alu_data = 32'h500;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_q.delete();
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1;
    issue(1'b1, 3'b000, 32'h7, 32'h5A, 32'h0, 3, 1'b0);

`ifdef LSU_TIMEOUT_EN
    issue(1'b0, 3'b010, 32'h600, 32'h0, 32'h12345678, 0, 1'b0);
`endif

    for (int n = 0; n < 300 && !abort; n++) begin
      int          gap;
      logic [31:0] a;
      gap = $urandom_range(2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      a = $urandom;
      if ($urandom_range(1) == 1) a[1:0] = 2'b00;
      issue(1'($urandom_range(1)), 3'($urandom_range(7)), a, $urandom, $urandom,
            $urandom_range(6, 1), 1'($urandom_range(1)));
    end

    if (!abort) begin
      repeat (3) @(posedge clk);
      chk("exp_queue_drained", 32'(exp_q.size()), 0);
      chk("req_queue_drained", 32'(req_q.size()), 0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Multi-cycle load/store unit sitting directly downstream of the ALU in the RISC-V core. It takes the ALU result as the effective address and the rs2 value as store data, then performs one request/acknowledge transaction on the data-memory port. It returns sign- or zero-extended load data and a stall signal that freezes the PC and register writeback until the access completes.

## Interface
- WIDTH, 32, datapath and address width; only 32 is supported.
- TIMEOUT, 16, watchdog limit in cycles; used only with LSU_TIMEOUT_EN.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous reset, active high.
- i_lsu_valid  in  1  a load or store is presented this cycle.
- i_lsu_wren  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- i_alu_data  in  WIDTH  effective address, taken from the ALU output.
- i_rs2_data  in  WIDTH  store data.
- o_stall  out  1  combinational; freezes the PC and regfile write.
- o_done  out  1  one-cycle pulse when the access completes.
- o_ld_data  out  WIDTH  extended load data; valid while o_done.
- o_misaligned  out  1  valid with o_done; set on misalignment or illegal funct3.
- o_bus_err  out  1  valid with o_done; set on watchdog timeout.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  write enable.
- o_mem_addr  out  WIDTH  word-aligned address, {addr[31:2],2'b00}.
- o_mem_wdata  out  WIDTH  lane-replicated store data.
- o_mem_bmask  out  4  byte-lane enables.
- i_mem_ack  in  1  memory accepted the write / returned the read.
- i_mem_rdata  in  WIDTH  read word; valid while i_mem_ack.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - On i_lsu_valid, capture wren, funct3, address, store data and byte mask into registers.
  - Aligned, legal access: go to BUSY.
  - Misaligned or illegal access: go to RESP with the error flag set; no memory request is issued.
- **Alignment rules**
  - H/HU: addr[0] must be 0.
  - W: addr[1:0] must be 00.
  - Illegal funct3: 011, 110, 111 for loads; anything other than 000/001/010 for stores.
- **BUSY**
  - o_mem_req = 1 and all o_mem_* outputs are held stable until i_mem_ack.
  - On ack, latch i_mem_rdata (loads) and go to RESP.
- **RESP**
  - o_done = 1 for exactly one cycle, then return to IDLE.
- **Stall:** o_stall = (IDLE & i_lsu_valid) | BUSY. It is 0 in RESP, so the instruction retires there.
- **Store lanes** (b = addr[1:0]):
  - SB: wdata = {4{rs2[7:0]}}, mask = 0001 << b.
  - SH: wdata = {2{rs2[15:0]}}, mask = 0011 (b = 00) or 1100 (b = 10).
  - SW: wdata = rs2, mask = 1111.
- **Loads:** o_mem_bmask = 1111 and o_mem_we = 0.
  - Select byte b, or halfword b[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
  - o_ld_data = 0 when not in RESP, on any error, and for stores.
- i_lsu_valid is ignored outside IDLE; upstream re-presents the same instruction while stalled.
- i_mem_ack outside BUSY is ignored.

## Timing
- **Reset values:** state = IDLE; o_mem_req, o_mem_we, o_done, o_misaligned and o_bus_err = 0; o_mem_addr, o_mem_wdata, o_ld_data = 0; o_mem_bmask = 0000.
- Reset mid-transaction returns to IDLE at the same edge. o_mem_req drops the following cycle and no o_done is produced.
- **Cycle accounting:** valid accepted at cycle 0; o_mem_req is high from cycle 1 through the ack cycle k (k ≥ 1); o_done at cycle k+1.
  - Minimum latency is 2 cycles after acceptance (ack in cycle 1).
- Error path: o_done at cycle 1 with no o_mem_req.
- Back-to-back accesses: a new valid is accepted in the IDLE cycle immediately after RESP, so the issue interval is at least 3 cycles.

## Configuration
- **LSU_TIMEOUT_EN defined:**
  - A 5-bit counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT−1 without ack: drop o_mem_req, go to RESP, assert o_bus_err, and force o_ld_data = 0.
  - An ack in the same cycle the limit is reached wins: normal completion.
- **LSU_TIMEOUT_EN undefined:** no counter exists, BUSY waits indefinitely, and o_bus_err is tied to 0.

## Test plan
- LW at 0x100, ack in cycle 1 with rdata 0xDEADBEEF:
  - o_mem_addr = 0x100, bmask = 1111.
  - o_done at cycle 2 with o_ld_data = 0xDEADBEEF.
  - o_stall = 1 in cycles 0–1.
- LB and LBU at 0x203, rdata 0x80FF1234, ack delayed 4 cycles:
  - LB returns 0xFFFFFF80; LBU returns 0x00000080.
  - o_mem_req is held for 4 cycles.
- SH at 0x302 with rs2 = 0x0000ABCD:
  - o_mem_we = 1, addr = 0x300, wdata = 0xABCDABCD, bmask = 1100.
  - o_done follows the ack.
- LW at 0x101, then SH at 0x401:
  - o_misaligned = 1 with o_done at cycle 1.
  - o_mem_req is never asserted.
- Assert i_rst while BUSY:
  - IDLE at the next edge, all outputs at reset values.
  - A subsequent SB at 0x7 (rs2 = 0x5A) gives wdata = 0x5A5A5A5A, bmask = 1000.
- With LSU_TIMEOUT_EN and TIMEOUT = 16, no ack:
  - o_done with o_bus_err = 1 exactly 16 cycles after entering BUSY.
  - o_ld_data = 0.
